sargantana_icache_ifill_arbiter: RTL

- Shares the single icache refill port to upper levels between two requesters: demand misses from the icache and a next-line prefetcher.
- Keeps at most one refill outstanding and routes the returning line to its owner.
- Handles flush by draining the in-flight request; the bus request is never cancelled.
- Sits between the icache miss logic or prefetcher and the ifill request/response interface.

---
 rtl/sargantana_icache_ifill_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sargantana_icache_ifill_arbiter.sv
// Refill port arbiter for the icache: demand misses vs. next-line prefetch.
// One refill in flight; flush drains it without cancelling the bus request.
module sargantana_icache_ifill_arbiter #(
    parameter int unsigned PADDR_SIZE     = 40,
    parameter int unsigned LINE_W         = 128,
    parameter int unsigned MAX_DMD_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  flush_i,
    input  logic                  dmd_req_valid_i,
    input  logic [PADDR_SIZE-1:0] dmd_req_paddr_i,
    output logic                  dmd_req_ready_o,
    input  logic                  pf_req_valid_i,
    input  logic [PADDR_SIZE-1:0] pf_req_paddr_i,
    output logic                  pf_req_ready_o,
    output logic                  ifill_req_valid_o,
    output logic [PADDR_SIZE-1:0] ifill_req_paddr_o,
    input  logic                  ifill_resp_valid_i,
    input  logic                  ifill_resp_ack_i,
    input  logic [LINE_W-1:0]     ifill_resp_data_i,
    output logic                  dmd_resp_valid_o,
    output logic                  pf_resp_valid_o,
    output logic [LINE_W-1:0]     resp_data_o,
    output logic                  busy_o
);

    localparam int unsigned SW = $clog2(MAX_DMD_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [SW-1:0]         streak_q;
    logic                  owner_pf_q;
    logic [PADDR_SIZE-1:0] paddr_q;
    logic                  dmd_resp_q;
    logic                  pf_resp_q;
    logic [LINE_W-1:0]     data_q;

    logic idle;
    logic open;
    logic streak_full;
    logic dmd_grant;
    logic pf_grant;
    logic complete;
    logic deliver;

    assign idle        = (state_q == IDLE);
    assign open        = idle & ~flush_i & rstn_i;
    assign streak_full = (streak_q == SW'(MAX_DMD_STREAK));
    assign complete    = ifill_resp_valid_i & ifill_resp_ack_i;

    // A starved prefetch takes the slot away from demand.
    assign dmd_req_ready_o = open & ~(pf_req_valid_i & streak_full);
    assign pf_req_ready_o  = open & (~dmd_req_valid_i | streak_full);

    assign dmd_grant = dmd_req_valid_i & dmd_req_ready_o;
    assign pf_grant  = pf_req_valid_i & pf_req_ready_o;

    // Only a clean completion in BUSY hands the line to its owner.
    assign deliver = (state_q == BUSY) & complete & ~flush_i;

    assign ifill_req_valid_o = ~idle;
    assign ifill_req_paddr_o = paddr_q;
    assign busy_o            = ~idle;
    assign dmd_resp_valid_o  = dmd_resp_q;
    assign pf_resp_valid_o   = pf_resp_q;
    assign resp_data_o       = data_q;

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant opens a refill, completion closes it, flush drains.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (dmd_grant | pf_grant) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (complete) begin
                    state_d = IDLE;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, fairness streak and response delivery.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            streak_q   <= '0;
            owner_pf_q <= 1'b0;
            paddr_q    <= '0;
            dmd_resp_q <= 1'b0;
            pf_resp_q  <= 1'b0;
            data_q     <= '0;
        end else begin
            if (dmd_grant) begin
                paddr_q    <= dmd_req_paddr_i;
                owner_pf_q <= 1'b0;
                if (!pf_req_valid_i) begin
                    streak_q <= '0;
                end else if (!streak_full) begin
                    streak_q <= streak_q + SW'(1);
                end
            end else if (pf_grant) begin
                paddr_q    <= pf_req_paddr_i;
                owner_pf_q <= 1'b1;
                streak_q   <= '0;
            end
            dmd_resp_q <= deliver & ~owner_pf_q;
            pf_resp_q  <= deliver & owner_pf_q;
            if (deliver) begin
                data_q <= ifill_resp_data_i;
            end
        end
    end

endmodule
